// File: rtl/multi_cycle_adder_if.sv
// multi_cycle_adder_if
//   Handshake and data bundle for multi_cycle_adder.
//   master : operand producer / result consumer side
//   slave  : the adder itself
// Signals:
//   io_in_valid / io_in_ready   operand handshake
//   io_a, io_b, io_cin, io_sub  operands and operation select
//   io_out_valid / io_out_ready result handshake
//   io_sum, io_cout             result and carry out of the MSB
//   io_overflow                 signed overflow, present only when
//                               MULTI_CYCLE_ADDER_OVERFLOW_EN is defined
interface multi_cycle_adder_if #(
  parameter int WIDTH = 32
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_a;
  logic [WIDTH-1:0] io_b;
  logic             io_cin;
  logic             io_sub;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_sum;
  logic             io_cout;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
  logic             io_overflow;

  modport master (
    output io_in_valid, io_a, io_b, io_cin, io_sub, io_out_ready,
    input  io_in_ready, io_out_valid, io_sum, io_cout, io_overflow
  );

  modport slave (
    input  io_in_valid, io_a, io_b, io_cin, io_sub, io_out_ready,
    output io_in_ready, io_out_valid, io_sum, io_cout, io_overflow
  );
`else
  modport master (
    output io_in_valid, io_a, io_b, io_cin, io_sub, io_out_ready,
    input  io_in_ready, io_out_valid, io_sum, io_cout
  );

  modport slave (
    input  io_in_valid, io_a, io_b, io_cin, io_sub, io_out_ready,
    output io_in_ready, io_out_valid, io_sum, io_cout
  );
`endif
endinterface

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder
//   WIDTH-bit add/subtract unit that adds DIGIT bits per cycle, LSB digit
//   first, through a registered carry. One operation in flight at a time.
//   Optional feature macro: MULTI_CYCLE_ADDER_OVERFLOW_EN (adds io_overflow).
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   io     multi_cycle_adder_if.slave (operand / result handshakes)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for operands (io_in_ready=1)
// RUN   | adding one digit per edge, digit index idx_q
// DONE  | result presented (io_out_valid=1) until io_out_ready
module multi_cycle_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  multi_cycle_adder_if.slave io
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;        // already inverted for subtract
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             accept;
  logic             step;
  logic             last_digit;
  logic             in_ready;
  logic             out_valid;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;

  assign last_digit = (idx_q == IDX_W'(STEPS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (io.io_in_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_digit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (io.io_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Digit select by comparing against every constant digit position keeps
  // all part-select bases constant.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int j = 0; j < STEPS; j++) begin
      if (idx_q == IDX_W'(j)) begin
        a_dig = a_q[j*DIGIT +: DIGIT];
        b_dig = b_q[j*DIGIT +: DIGIT];
      end
    end
  end

  assign {dig_cout, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1; cin is ignored in that case.
      a_q     <= io.io_a;
      b_q     <= io.io_sub ? ~io.io_b : io.io_b;
      carry_q <= io.io_sub ? 1'b1 : io.io_cin;
      idx_q   <= '0;
    end else if (step) begin
      for (int j = 0; j < STEPS; j++) begin
        if (idx_q == IDX_W'(j)) begin
          sum_q[j*DIGIT +: DIGIT] <= dig_sum;
        end
      end
      carry_q <= dig_cout;
      idx_q   <= idx_q + 1'b1;
      if (last_digit) begin
        cout_q <= dig_cout;
      end
    end
  end

`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
  logic ovf_q;

  // The final digit result carries the sum MSB, so overflow is resolved on
  // the same edge as cout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (step && last_digit) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (dig_sum[DIGIT-1] != a_q[WIDTH-1]);
    end
  end

  assign io.io_overflow = ovf_q;
`endif

  assign io.io_in_ready  = in_ready;
  assign io.io_out_valid = out_valid;
  assign io.io_sum       = sum_q;
  assign io.io_cout      = cout_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb_multi_cycle_adder
//   Scoreboard bench for multi_cycle_adder at WIDTH=8, DIGIT=2.
//   Expected results are pushed when an operand set is issued; a monitor
//   pops and compares on every rising edge of io_out_valid, including the
//   cycle at which the result appears.
module tb_multi_cycle_adder;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int STEPS = WIDTH / DIGIT;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  multi_cycle_adder_if #(.WIDTH(WIDTH)) io ();

  multi_cycle_adder #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (io)
  );

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_v   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int ua, ub, sa, sb, full, rs;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      full   = ua - ub;
      e.cout = (ua >= ub);
      rs     = sa - sb;
    end else begin
      full   = ua + ub + int'(cin);
      e.cout = (full > 255);
      rs     = sa + sb + int'(cin);
    end
    e.sum = full[7:0];
    e.ovf = (rs > 127) || (rs < -128);
    e.due = 0;
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset && io.io_out_valid && !prev_v) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sum", 32'(io.io_sum), 32'(e.sum));
        chk("cout", 32'(io.io_cout), 32'(e.cout));
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
        chk("overflow", 32'(io.io_overflow), 32'(e.ovf));
`endif
        chk("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
    prev_v <= reset && io.io_out_valid;
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input bit keep, output int acc_cyc);
    exp_t e;
    int   n;
    io.io_a        = a;
    io.io_b        = b;
    io.io_cin      = cin;
    io.io_sub      = sub;
    io.io_in_valid = 1'b1;
    n = 0;
    acc_cyc = -1;
    while (!io.io_in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!io.io_in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      io.io_in_valid = 1'b0;
      return;
    end
    e       = model(a, b, cin, sub);
    e.due   = cyc + 1 + STEPS;
    acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (!keep) io.io_in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!io.io_out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!io.io_out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    io.io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    io.io_out_ready = 1'b0;
    chk("idle_after_take", 32'(io.io_in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, dummy;
    io.io_in_valid  = 1'b0;
    io.io_a         = '0;
    io.io_b         = '0;
    io.io_cin       = 1'b0;
    io.io_sub       = 1'b0;
    io.io_out_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(io.io_in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.io_out_valid), 32'd0);
    chk("rst_sum", 32'(io.io_sum), 32'd0);
    chk("rst_cout", 32'(io.io_cout), 32'd0);
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
    chk("rst_overflow", 32'(io.io_overflow), 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed operations.
    issue(8'h3C, 8'h45, 1'b0, 1'b0, 1'b0, dummy); wait_valid(); take();
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, dummy); wait_valid(); take();
    issue(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, dummy); wait_valid(); take();

    // Hold the result with a competing operand set presented.
    issue(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, dummy);
    wait_valid();
    io.io_a        = 8'h11;
    io.io_b        = 8'h22;
    io.io_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("hold_valid", 32'(io.io_out_valid), 32'd1);
      chk("hold_in_ready", 32'(io.io_in_ready), 32'd0);
      chk("hold_sum", 32'(io.io_sum), 32'h80);
      chk("hold_cout", 32'(io.io_cout), 32'd0);
    end
    io.io_in_valid = 1'b0;
    take();
    for (int k = 0; k < STEPS + 2; k++) begin
      @(negedge clock);
      chk("no_ghost_op", 32'(io.io_out_valid), 32'd0);
    end

    // Reset in the middle of RUN discards the operation.
    issue(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, dummy);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("abort_in_ready", 32'(io.io_in_ready), 32'd1);
    chk("abort_out_valid", 32'(io.io_out_valid), 32'd0);
    chk("abort_sum", 32'(io.io_sum), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < STEPS + 4; k++) begin
      @(negedge clock);
      chk("abort_no_valid", 32'(io.io_out_valid), 32'd0);
    end
    chk("abort_idle", 32'(io.io_in_ready), 32'd1);
    issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, dummy); wait_valid(); take();

    // Back-to-back with valid and ready held high.
    @(negedge clock);
    io.io_out_ready = 1'b1;
    issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, acc1);
    issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, acc2);
    chk("b2b_spacing", 32'(acc2 - acc1), 32'(STEPS + 2));
    repeat (STEPS + 2) @(negedge clock);
    io.io_out_ready = 1'b0;
    @(negedge clock);

    // Randomised operations with random consumer delay.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, rs, 1'b0, dummy);
      wait_valid();
      repeat ($urandom_range(0, 3)) @(negedge clock);
      take();
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
